// File: rtl/tsp16_pkg.sv
// Shared TSP16 pipeline constants and the writeback-stage state type.
package tsp16_pkg;

   localparam int unsigned DATA_W      = 16;
   localparam int unsigned OPCODE_MSB  = 15;
   localparam int unsigned OPCODE_LSB  = 12;
   localparam logic [3:0]  HALT_OPCODE = 4'hF;

   typedef enum logic [0:0] {
      WB_RUN    = 1'b0,
      WB_HALTED = 1'b1
   } wb_state_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with async-reset storage and write-first read bypass.
module regfile_2r1w
   import tsp16_pkg::*;
#(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned DATA_W   = tsp16_pkg::DATA_W,
   parameter bit          R0_ZERO  = 1'b1,
   localparam int unsigned AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr_a,
   input  logic [AW-1:0]     rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Out-of-range addresses (non-power-of-2 NUM_REGS) read as zero.
   function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] addr);
      logic [DATA_W-1:0] data;
      data = '0;
      if (R0_ZERO && addr == '0) begin
         data = '0;
      end else if (we && addr == wr_addr) begin
         data = wr_data;
      end else if (32'(addr) < NUM_REGS) begin
         data = regs[addr];
      end
      return data;
   endfunction

   always_comb begin
      rd_data_a = read_port(rd_addr_a);
      rd_data_b = read_port(rd_addr_b);
   end

endmodule

// File: rtl/pipeline_writeback.sv
// TSP16 writeback stage: commits memory-stage results to the register file,
// re-presents them for forwarding, counts retirements and halts on HALT.
module pipeline_writeback #(
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned RD_LSB      = 8,
   parameter logic [3:0]  HALT_OPCODE = tsp16_pkg::HALT_OPCODE,
   parameter int unsigned CNT_W       = 32,
   parameter bit          R0_ZERO     = 1'b1,
   localparam int unsigned AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   localparam int unsigned DW         = tsp16_pkg::DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memory_done,
   input  logic             memory_is_dependent,
   input  logic [DW-1:0]    memory_result,
   input  logic [DW-1:0]    memory_instr,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [DW-1:0]    rd_data_a,
   output logic [DW-1:0]    rd_data_b,
   output logic             writeback_done,
   output logic             writeback_is_dependent,
   output logic [DW-1:0]    writeback_result,
   output logic [DW-1:0]    writeback_instr,
   output logic [AW-1:0]    writeback_rd,
   output logic             halted,
   output logic [CNT_W-1:0] retired_count
);

   import tsp16_pkg::*;

   wb_state_t         state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [AW-1:0]     rd;
   logic              commit;
   logic              rd_ok;
   logic              we;
   logic              is_halt;

   always_comb begin
      rd      = memory_instr[RD_LSB +: AW];
      commit  = (state_q == WB_RUN) && memory_done;
      rd_ok   = (32'(rd) < NUM_REGS) && !(R0_ZERO && rd == '0);
      we      = commit && memory_is_dependent && rd_ok;
      is_halt = memory_instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
   end

   regfile_2r1w #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DW),
      .R0_ZERO  (R0_ZERO)
   ) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .wr_addr   (rd),
      .wr_data   (memory_result),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q                <= WB_RUN;
         cnt_q                  <= '0;
         writeback_done         <= 1'b0;
         writeback_is_dependent <= 1'b0;
         writeback_result       <= '0;
         writeback_instr        <= '0;
         writeback_rd           <= '0;
      end else if (state_q == WB_RUN) begin
         writeback_done         <= memory_done;
         writeback_is_dependent <= we;
         writeback_result       <= memory_result;
         writeback_instr        <= memory_instr;
         writeback_rd           <= rd;
         if (commit) begin
            if (!(&cnt_q)) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
            if (is_halt) begin
               state_q <= WB_HALTED;
            end
         end
      end else begin
         // Halted: payload fields keep their last committed values.
         writeback_done         <= 1'b0;
         writeback_is_dependent <= 1'b0;
      end
   end

   assign halted        = (state_q == WB_HALTED);
   assign retired_count = cnt_q;

endmodule

// File: tb/tb_pipeline_writeback.sv
// Directed scoreboard bench for pipeline_writeback (32-bit counter DUT plus a 2-bit counter twin).
module tb_pipeline_writeback;

   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          memory_done, memory_is_dependent;
   logic [15:0]   memory_result, memory_instr;
   logic [AW-1:0] rd_addr_a, rd_addr_b;
   logic [15:0]   rd_data_a, rd_data_b;
   logic          writeback_done, writeback_is_dependent;
   logic [15:0]   writeback_result, writeback_instr;
   logic [AW-1:0] writeback_rd;
   logic          halted;
   logic [31:0]   retired_count;

   logic [15:0]   s_rd_data_a, s_rd_data_b, s_wb_result, s_wb_instr;
   logic          s_wb_done, s_wb_dep, s_halted;
   logic [AW-1:0] s_wb_rd;
   logic [1:0]    s_count;

   pipeline_writeback dut (
      .clk(clk), .reset(reset),
      .memory_done(memory_done), .memory_is_dependent(memory_is_dependent),
      .memory_result(memory_result), .memory_instr(memory_instr),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .writeback_done(writeback_done), .writeback_is_dependent(writeback_is_dependent),
      .writeback_result(writeback_result), .writeback_instr(writeback_instr),
      .writeback_rd(writeback_rd), .halted(halted), .retired_count(retired_count)
   );

   pipeline_writeback #(.CNT_W(2)) dut_small (
      .clk(clk), .reset(reset),
      .memory_done(memory_done), .memory_is_dependent(memory_is_dependent),
      .memory_result(memory_result), .memory_instr(memory_instr),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b),
      .writeback_done(s_wb_done), .writeback_is_dependent(s_wb_dep),
      .writeback_result(s_wb_result), .writeback_instr(s_wb_instr),
      .writeback_rd(s_wb_rd), .halted(s_halted), .retired_count(s_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        done;
      logic        dep;
      logic [15:0] result;
      logic [15:0] instr;
      logic [3:0]  rd;
      logic        halted;
      logic [31:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t        sb[$];
   exp_t        m_last;
   logic [15:0] m_regs [16];
   logic [31:0] m_cnt;
   logic [1:0]  m_cnt2;
   logic        m_halted;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_cnt    = '0;
      m_cnt2   = '0;
      m_halted = 1'b0;
      m_last   = '0;
      sb.delete();
   endtask

   function automatic logic [15:0] exp_read(input logic [3:0] a);
      logic [3:0] rd;
      logic       we;
      rd = memory_instr[11:8];
      we = !m_halted && memory_done && memory_is_dependent && rd != 4'd0;
      if (a == 4'd0) return 16'h0000;
      if (we && a == rd) return memory_result;
      return m_regs[a];
   endfunction

   task automatic drive(input logic d, input logic dep, input logic [15:0] instr,
                        input logic [15:0] result);
      memory_done         = d;
      memory_is_dependent = dep;
      memory_instr        = instr;
      memory_result       = result;
   endtask

   task automatic read_chk(input string tag, input logic [3:0] a, input logic [3:0] b);
      rd_addr_a = a;
      rd_addr_b = b;
      #1;
      chk({tag, "_rda"}, 32'(rd_data_a), 32'(exp_read(a)));
      chk({tag, "_rdb"}, 32'(rd_data_b), 32'(exp_read(b)));
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "_done"},   32'(writeback_done), 32'd0);
      chk({tag, "_dep"},    32'(writeback_is_dependent), 32'd0);
      chk({tag, "_result"}, 32'(writeback_result), 32'd0);
      chk({tag, "_instr"},  32'(writeback_instr), 32'd0);
      chk({tag, "_rd"},     32'(writeback_rd), 32'd0);
      chk({tag, "_halted"}, 32'(halted), 32'd0);
      chk({tag, "_count"},  retired_count, 32'd0);
   endtask

   // Push the expected post-edge state, clock once, then pop and compare.
   task automatic tick(input string tag);
      exp_t       e;
      exp_t       got;
      logic [3:0] rd;
      rd = memory_instr[11:8];
      e  = m_last;
      if (!m_halted) begin
         e.done   = memory_done;
         e.dep    = memory_done && memory_is_dependent && rd != 4'd0;
         e.result = memory_result;
         e.instr  = memory_instr;
         e.rd     = rd;
         if (memory_done) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            if (m_cnt2 != 2'd3) m_cnt2++;
            if (memory_is_dependent && rd != 4'd0) m_regs[rd] = memory_result;
            if (memory_instr[15:12] == 4'hF) m_halted = 1'b1;
         end
      end else begin
         e.done = 1'b0;
         e.dep  = 1'b0;
      end
      e.halted = m_halted;
      e.cnt    = m_cnt;
      e.cnt2   = m_cnt2;
      m_last   = e;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({tag, "_wb_done"},   32'(writeback_done), 32'(got.done));
      chk({tag, "_wb_dep"},    32'(writeback_is_dependent), 32'(got.dep));
      chk({tag, "_wb_result"}, 32'(writeback_result), 32'(got.result));
      chk({tag, "_wb_instr"},  32'(writeback_instr), 32'(got.instr));
      chk({tag, "_wb_rd"},     32'(writeback_rd), 32'(got.rd));
      chk({tag, "_halted"},    32'(halted), 32'(got.halted));
      chk({tag, "_count"},     retired_count, got.cnt);
      chk({tag, "_count2"},    32'(s_count), 32'(got.cnt2));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      rd_addr_a = '0;
      rd_addr_b = '0;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_chk("por");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Basic commit to r3
      drive(1'b1, 1'b1, 16'h1300, 16'hBEEF);
      read_chk("c1_pre", 4'd3, 4'd3);
      tick("c1");
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      read_chk("c1_post", 4'd3, 4'd0);

      // Same-cycle bypass on both ports, then a write aimed at r0
      drive(1'b1, 1'b1, 16'h2500, 16'h1234);
      read_chk("byp", 4'd5, 4'd5);
      read_chk("byp2", 4'd3, 4'd5);
      tick("byp");
      drive(1'b1, 1'b1, 16'h3000, 16'hFFFF);
      read_chk("r0_pre", 4'd0, 4'd5);
      tick("r0");
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      read_chk("r0_post", 4'd0, 4'd3);

      // Non-writing commit, then a bubble
      drive(1'b1, 1'b0, 16'h2700, 16'h5555);
      read_chk("nodep_pre", 4'd7, 4'd5);
      tick("nodep");
      drive(1'b0, 1'b1, 16'h2800, 16'h6666);
      read_chk("bubble_pre", 4'd8, 4'd7);
      tick("bubble");
      read_chk("bubble_post", 4'd8, 4'd7);

      // Fill every register
      for (int i = 1; i < 16; i++) begin
         logic [15:0] ins;
         ins = 16'h4000 | 16'(i << 8);
         drive(1'b1, 1'b1, ins, 16'(i * 16'h0F1D));
         tick("fill");
      end
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      for (int i = 0; i < 16; i += 2) read_chk("fill_rd", 4'(i), 4'(i + 1));

      // Asynchronous reset with a commit in flight
      drive(1'b1, 1'b1, 16'h1900, 16'h9999);
      #2;
      reset = 1'b1;
      #1;
      reset_chk("areset");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      for (int i = 0; i < 16; i++) read_chk("areset_rd", 4'(i), 4'(15 - i));
      @(posedge clk);
      #1;

      // Halt commits (with a write), then later commits are ignored
      drive(1'b1, 1'b1, 16'h1400, 16'h4444);
      tick("pre_halt");
      drive(1'b1, 1'b1, 16'hF200, 16'hA5A5);
      tick("halt");
      drive(1'b1, 1'b1, 16'h1400, 16'h7777);
      read_chk("halted_pre", 4'd4, 4'd2);
      tick("halted1");
      drive(1'b1, 1'b1, 16'h2600, 16'h8888);
      tick("halted2");
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      read_chk("halted_rd", 4'd4, 4'd6);
      read_chk("halted_rd2", 4'd2, 4'd2);

      // Counter saturation near the top of the 32-bit range
      reset = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      force dut.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.cnt_q;
      m_cnt = 32'hFFFF_FFFE;
      m_last.cnt = m_cnt;
      chk("sat_preload", retired_count, 32'hFFFF_FFFE);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 16'h0100, 16'(i));
         tick("sat");
      end
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      tick("sat_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
